pkt_out_fifo: RTL and testbench

- Per-destination output buffer directly downstream of the router input channel.
- One instance per destination port (0..3). Its wr_en is driven by the matching pkt_to_fifo_en<n>; its data_in is driven by the channel's data_out.
- Stores whole packets, counts complete packets, and replays each packet to the output side on request as a contiguous burst.
- Detects overflow and malformed headers, and reports them through sticky error flags.

---
 rtl/router_pkg.sv | 31 +++
 rtl/pkt_out_fifo_if.sv | 33 +++
 rtl/sync_fifo_mem.sv | 54 +++++
 rtl/pkt_out_fifo.sv | 117 +++++++++++
 tb/tb_pkt_out_fifo.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared router definitions used by the per-destination output buffers.
//   data_size        : byte width of the router datapath
//   pkt_length_bits  : width of the length field in a header byte
//   pkt_addr_bits    : remaining header bits, the destination address
//   pkt_hdr_t        : header byte layout {addr, len}
//   rd_state_t       : replay FSM states
package router_pkg;

  localparam int data_size          = 8;
  localparam int pkt_length_bits    = 5;
  localparam int pkt_addr_bits      = data_size - pkt_length_bits;
  localparam int depth_log2         = 6;
  localparam int almost_full_margin = 4;

  typedef struct packed {
    logic [pkt_addr_bits-1:0]   addr;
    logic [pkt_length_bits-1:0] len;
  } pkt_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } rd_state_t;

  // Payload length carried in a header byte.
  function automatic logic [pkt_length_bits-1:0] hdr_len(input pkt_hdr_t h);
    return h.len;
  endfunction

endpackage

// File: rtl/pkt_out_fifo_if.sv
// Bundle of the write, replay and status signals of one output buffer.
//   master : drives clr_errors, wr_en, data_in, rd_req; observes the rest
//   slave  : the buffer itself
interface pkt_out_fifo_if #(
  parameter int width = router_pkg::data_size
) ();

  logic             clr_errors;
  logic             wr_en;
  logic [width-1:0] data_in;
  logic             rd_req;
  logic [width-1:0] data_out;
  logic             data_valid;
  logic             pkt_avail;
  logic             full;
  logic             almost_full;
  logic             empty;
  logic             overflow_err;
  logic             len_err;

  modport master (
    output clr_errors, wr_en, data_in, rd_req,
    input  data_out, data_valid, pkt_avail, full, almost_full, empty,
           overflow_err, len_err
  );

  modport slave (
    input  clr_errors, wr_en, data_in, rd_req,
    output data_out, data_valid, pkt_avail, full, almost_full, empty,
           overflow_err, len_err
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// Single-clock byte store with wrapping read/write pointers.
//   push/push_data : write one entry (ignored when full)
//   pop/pop_data   : pop_data shows the head entry; pop advances past it
//   occupancy      : wr_ptr - rd_ptr
//   full, almost_full, empty : decoded from the registered pointers
module sync_fifo_mem #(
  parameter int width              = router_pkg::data_size,
  parameter int depth_log2         = router_pkg::depth_log2,
  parameter int almost_full_margin = router_pkg::almost_full_margin
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic [depth_log2:0] occupancy,
  output logic             full,
  output logic             almost_full,
  output logic             empty
);

  localparam logic [depth_log2:0] depth_c = (depth_log2+1)'(2**depth_log2);
  localparam logic [depth_log2:0] af_c    = depth_c - (depth_log2+1)'(almost_full_margin);
  localparam logic [depth_log2:0] one_c   = (depth_log2+1)'(1);

  logic [width-1:0]    mem [2**depth_log2];
  logic [depth_log2:0] wr_ptr;
  logic [depth_log2:0] rd_ptr;

  // The extra pointer bit separates full from empty when the indices match.
  assign occupancy   = wr_ptr - rd_ptr;
  assign full        = (occupancy == depth_c);
  assign almost_full = (occupancy >= af_c);
  assign empty       = (occupancy == '0);
  assign pop_data    = mem[rd_ptr[depth_log2-1:0]];

  // NOTE: storage has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[depth_log2-1:0]] <= push_data;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + one_c;
      if (pop && !empty) rd_ptr <= rd_ptr + one_c;
    end
  end

endmodule

// File: rtl/pkt_out_fifo.sv
// Per-destination output buffer: stores whole packets, counts completed
// packets and replays the oldest one as a gapless burst on rd_req.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : pkt_out_fifo_if.slave (write side, replay side, status/errors)
module pkt_out_fifo
  import router_pkg::*;
#(
  parameter int fifo_depth_log2 = router_pkg::depth_log2,
  parameter int af_margin       = router_pkg::almost_full_margin
) (
  input  logic           clk,
  input  logic           rstn,
  pkt_out_fifo_if.slave  bus
);

  localparam logic [fifo_depth_log2:0]  cnt_one = (fifo_depth_log2+1)'(1);
  localparam logic [pkt_length_bits-1:0] rem_one = pkt_length_bits'(1);

  logic                       wr_en_q;
  logic                       sop, eop;
  logic                       mem_full, mem_empty;
  logic [data_size-1:0]       mem_rd;
  logic [fifo_depth_log2:0]   occupancy;
  logic [fifo_depth_log2:0]   pkt_count;
  logic [pkt_length_bits-1:0] rem;
  rd_state_t                  state;
  logic                       start, done, pop;

  assign sop = bus.wr_en && !wr_en_q;
  assign eop = wr_en_q && !bus.wr_en;

  // pkt_avail lags pkt_count by one cycle, so a request right after the last
  // packet drained must also see the live count.
  assign start = (state == IDLE) && bus.rd_req && bus.pkt_avail && (pkt_count != '0);
  assign done  = (state != IDLE) && (rem == '0);
  assign pop   = start || ((state != IDLE) && (rem != '0));

  sync_fifo_mem #(
    .width              (data_size),
    .depth_log2         (fifo_depth_log2),
    .almost_full_margin (af_margin)
  ) u_mem (
    .clk         (clk),
    .rstn        (rstn),
    .push        (bus.wr_en),
    .push_data   (bus.data_in),
    .pop         (pop),
    .pop_data    (mem_rd),
    .occupancy   (occupancy),
    .full        (mem_full),
    .almost_full (bus.almost_full),
    .empty       (mem_empty)
  );

  assign bus.full  = mem_full;
  assign bus.empty = mem_empty;

  // Write-side tracking, packet counter and sticky errors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q          <= 1'b0;
      pkt_count        <= '0;
      bus.pkt_avail    <= 1'b0;
      bus.overflow_err <= 1'b0;
      bus.len_err      <= 1'b0;
    end else begin
      wr_en_q       <= bus.wr_en;
      bus.pkt_avail <= (pkt_count != '0);
      case ({eop, done})
        2'b10:   pkt_count <= pkt_count + cnt_one;
        2'b01:   pkt_count <= pkt_count - cnt_one;
        default: pkt_count <= pkt_count;
      endcase
      // A new error event wins over a clear in the same cycle.
      bus.overflow_err <= (bus.wr_en && mem_full) ||
                          (bus.overflow_err && !bus.clr_errors);
      bus.len_err      <= (sop && hdr_len(pkt_hdr_t'(bus.data_in)) == '0) ||
                          (bus.len_err && !bus.clr_errors);
    end
  end

  // Replay FSM: HDR presents the header, PAY the payload; rem counts the
  // payload bytes still to pop, so the burst is 1+len back-to-back bytes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      rem            <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.data_valid <= 1'b0;
          if (start) begin
            bus.data_out   <= mem_rd;
            bus.data_valid <= 1'b1;
            rem            <= hdr_len(pkt_hdr_t'(mem_rd));
            state          <= HDR;
          end
        end
        HDR, PAY: begin
          if (rem == '0) begin
            bus.data_valid <= 1'b0;
            state          <= IDLE;
          end else begin
            bus.data_out   <= mem_rd;
            bus.data_valid <= 1'b1;
            rem            <= rem - rem_one;
            state          <= PAY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_out_fifo.sv
// Directed bench for pkt_out_fifo with a scoreboard: reads push expected
// bytes, a negedge monitor pops and compares every data_valid byte and
// records the length of each contiguous valid burst.
module tb_pkt_out_fifo;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pkt_out_fifo_if bus ();

  pkt_out_fifo dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         runs[$];
  int         run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented byte and measures burst lengths.
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      run_len++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected no output at %0t", bus.data_out, $time);
      end else begin
        check("replay_byte", bus.data_out, exp_q.pop_front());
      end
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pkt(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      bus.wr_en   = 1'b1;
      bus.data_in = bytes[i];
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.data_in = 8'h00;
    tick();
  endtask

  task automatic wait_avail();
    int n = 0;
    while (bus.pkt_avail !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("pkt_avail_wait", bus.pkt_avail, 1);
  endtask

  // Requests one replay of pkt; extra keeps rd_req high one more cycle,
  // which lands while the FSM is busy and must be ignored.
  task automatic do_read(input logic [7:0] pkt[$], input bit extra);
    int n = 0;
    foreach (pkt[i]) exp_q.push_back(pkt[i]);
    runs.delete();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = extra;
    @(negedge clk);
    #1;
    check("first_valid_latency", bus.data_valid, 1);
    tick();
    bus.rd_req = 1'b0;
    while (runs.size() == 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("burst_len", (runs.size() != 0) ? runs[0] : 0, pkt.size());
    tick();
  endtask

  logic [7:0] pa[$];
  logic [7:0] pb[$];

  initial begin
    bus.clr_errors = 1'b0;
    bus.wr_en      = 1'b0;
    bus.data_in    = 8'h00;
    bus.rd_req     = 1'b0;
    #12;
    check("rst_data_valid",   bus.data_valid,   0);
    check("rst_data_out",     bus.data_out,     0);
    check("rst_pkt_avail",    bus.pkt_avail,    0);
    check("rst_full",         bus.full,         0);
    check("rst_almost_full",  bus.almost_full,  0);
    check("rst_empty",        bus.empty,        1);
    check("rst_overflow_err", bus.overflow_err, 0);
    check("rst_len_err",      bus.len_err,      0);
    rstn = 1'b1;
    tick();

    // Single 4-byte packet.
    pa = {8'h43, 8'h11, 8'h22, 8'h33};
    write_pkt(pa);
    check("avail_1_after_fall", bus.pkt_avail, 0);
    tick();
    check("avail_2_after_fall", bus.pkt_avail, 1);
    check("count_one", dut.pkt_count, 1);
    do_read(pa, 1'b0);
    check("t1_pkt_avail", bus.pkt_avail, 0);
    check("t1_empty",     bus.empty,     1);
    check("t1_len_err",   bus.len_err,   0);

    // Two packets read in order; extra request during the first is ignored.
    pa = {8'h62, 8'ha1, 8'ha2};
    pb = {8'h85, 8'hb1, 8'hb2, 8'hb3, 8'hb4, 8'hb5};
    write_pkt(pa);
    write_pkt(pb);
    tick();
    check("count_two", dut.pkt_count, 2);
    do_read(pa, 1'b1);
    check("count_after_first", dut.pkt_count, 1);
    do_read(pb, 1'b0);
    check("count_after_second", dut.pkt_count, 0);
    check("t2_empty", bus.empty, 1);

    // Zero-length header.
    pa = {8'h20};
    write_pkt(pa);
    check("len_err_set", bus.len_err, 1);
    wait_avail();
    do_read(pa, 1'b0);
    bus.clr_errors = 1'b1;
    bus.wr_en      = 1'b1;
    bus.data_in    = 8'h20;
    tick();
    bus.clr_errors = 1'b0;
    bus.wr_en      = 1'b0;
    check("len_err_set_wins", bus.len_err, 1);
    tick();
    bus.clr_errors = 1'b1;
    tick();
    bus.clr_errors = 1'b0;
    check("len_err_cleared", bus.len_err, 0);
    wait_avail();
    do_read(pa, 1'b0);
    check("t4_empty", bus.empty, 1);

    // 70-byte run into a 64-entry buffer.
    for (int k = 1; k <= 70; k++) begin
      bus.wr_en   = 1'b1;
      bus.data_in = (k == 1) ? 8'h01 : 8'(k);
      tick();
      if (k == 59) check("af_at_59",  bus.almost_full, 0);
      if (k == 60) check("af_at_60",  bus.almost_full, 1);
      if (k == 63) check("full_at_63", bus.full, 0);
      if (k == 64) begin
        check("full_at_64", bus.full, 1);
        check("ovf_at_64",  bus.overflow_err, 0);
      end
      if (k == 65) check("ovf_at_65", bus.overflow_err, 1);
    end
    bus.wr_en = 1'b0;
    tick();
    check("ovf_occupancy", dut.u_mem.occupancy, 64);
    check("ovf_sticky", bus.overflow_err, 1);
    bus.clr_errors = 1'b1;
    tick();
    bus.clr_errors = 1'b0;
    check("ovf_cleared", bus.overflow_err, 0);
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    tick();
    check("ovf_reset_empty", bus.empty, 1);

    // Streaming: packet B is written while A replays; B's end of packet
    // coincides with A's completion.
    pa = {8'h44, 8'hc1, 8'hc2, 8'hc3, 8'hc4};
    pb = {8'h23, 8'hd1, 8'hd2, 8'hd3};
    write_pkt(pa);
    wait_avail();
    fork
      do_read(pa, 1'b0);
      begin
        tick();
        write_pkt(pb);
      end
    join
    check("stream_count", dut.pkt_count, 1);
    check("stream_occupancy", dut.u_mem.occupancy, 4);
    do_read(pb, 1'b0);
    check("stream_empty", bus.empty, 1);
    check("stream_count_end", dut.pkt_count, 0);

    // Asynchronous reset in the middle of a replay.
    pa = {8'h45, 8'he1, 8'he2, 8'he3, 8'he4, 8'he5};
    write_pkt(pa);
    wait_avail();
    exp_q.push_back(8'h45);
    runs.delete();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    check("async_rst_valid", bus.data_valid, 0);
    check("async_rst_empty", bus.empty, 1);
    #2;
    rstn = 1'b1;
    tick();
    runs.delete();
    check("rst_exp_drained", exp_q.size(), 0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    repeat (10) tick();
    check("post_rst_no_burst", runs.size(), 0);
    check("post_rst_avail",    bus.pkt_avail, 0);
    pb = {8'h62, 8'hf1, 8'hf2};
    write_pkt(pb);
    wait_avail();
    do_read(pb, 1'b0);
    check("final_exp_empty", exp_q.size(), 0);
    check("final_empty", bus.empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
